exe_hazard_ctrl: RTL and testbench

Pipeline controller for the execute stage. It generates the forwarding selects for both ALU operands and detects load-use hazards. It also sequences multi-cycle MUL/DIV operations through an external iterative unit using a start/done handshake. It drives stall and bubble controls to the IF/ID/EXE/MEM pipeline registers and keeps a saturating stall-cycle counter.

---
 rtl/exe_hazard_ctrl_pkg.sv | 21 ++
 rtl/exe_hazard_ctrl_if.sv | 55 +++++
 rtl/exe_hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/exe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller:
// forwarding select encodings and the MUL/DIV sequencing states.
package exe_hazard_ctrl_pkg;

    localparam int XLEN              = 32;
    localparam int FORWARD_SEL_WIDTH = 2;
    localparam int MD_CNT_WIDTH      = 7;

    typedef logic [FORWARD_SEL_WIDTH-1:0] fwd_sel_t;

    localparam fwd_sel_t FORWARD_SEL_EXE = 2'd0;
    localparam fwd_sel_t FORWARD_SEL_MEM = 2'd1;
    localparam fwd_sel_t FORWARD_SEL_WB  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// Bundle of pipeline hazard inputs and stall/forward/MUL-DIV
// controls; master drives the pipeline side, slave is the controller.
interface exe_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);

    logic [REG_ADDR_WIDTH-1:0] rs1_addr_id;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_id;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_exe;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_exe;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_exe;
    logic                      mem_read_exe;
    logic                      md_op_exe;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_mem;
    logic                      reg_write_mem;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_wb;
    logic                      reg_write_wb;
    logic                      flush;
    logic                      md_done;

    exe_hazard_ctrl_pkg::fwd_sel_t forward_a_sel;
    exe_hazard_ctrl_pkg::fwd_sel_t forward_b_sel;
    logic                      stall_pc;
    logic                      stall_id;
    logic                      stall_exe;
    logic                      bubble_exe;
    logic                      bubble_mem;
    logic                      md_start;
    logic                      md_abort;
    logic                      md_result_sel;
    logic                      md_timeout;
    logic [CNT_WIDTH-1:0]      stall_count;

    modport master (
        output rs1_addr_id, rs2_addr_id, rs1_addr_exe, rs2_addr_exe,
        output rd_addr_exe, mem_read_exe, md_op_exe,
        output rd_addr_mem, reg_write_mem, rd_addr_wb, reg_write_wb,
        output flush, md_done,
        input  forward_a_sel, forward_b_sel,
        input  stall_pc, stall_id, stall_exe, bubble_exe, bubble_mem,
        input  md_start, md_abort, md_result_sel, md_timeout, stall_count
    );

    modport slave (
        input  rs1_addr_id, rs2_addr_id, rs1_addr_exe, rs2_addr_exe,
        input  rd_addr_exe, mem_read_exe, md_op_exe,
        input  rd_addr_mem, reg_write_mem, rd_addr_wb, reg_write_wb,
        input  flush, md_done,
        output forward_a_sel, forward_b_sel,
        output stall_pc, stall_id, stall_exe, bubble_exe, bubble_mem,
        output md_start, md_abort, md_result_sel, md_timeout, stall_count
    );

endinterface

// File: rtl/exe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator: picks the youngest in-flight
// writer of the source register, never forwarding x0.
module exe_hazard_ctrl_fwd_sel
    import exe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_mem,
    input  logic                      i_we_mem,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_wb,
    input  logic                      i_we_wb,
    output fwd_sel_t                  o_sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = i_we_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs_addr);
    assign w_hit_wb  = i_we_wb  && (i_rd_wb  != '0) && (i_rd_wb  == i_rs_addr);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        o_sel = FORWARD_SEL_EXE;
        if (w_hit_mem) begin
            o_sel = FORWARD_SEL_MEM;
        end else if (w_hit_wb) begin
            o_sel = FORWARD_SEL_WB;
        end
    end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use
// stalls, MUL/DIV sequencing with watchdog, and stall-cycle counter.
module exe_hazard_ctrl
    import exe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int MD_MAX_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    exe_hazard_ctrl_if.slave bus
);

    md_state_t               r_state;
    md_state_t               w_state_nxt;
    logic [MD_CNT_WIDTH-1:0] r_md_cnt;
    logic                    r_md_timeout;
    logic [CNT_WIDTH-1:0]    r_stall_count;

    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;
    logic     w_load_use;
    logic     w_wd_hit;
    logic     w_stall_pc;
    logic     w_stall_id;
    logic     w_stall_exe;
    logic     w_bubble_exe;
    logic     w_bubble_mem;
    logic     w_md_start;
    logic     w_md_abort;
    logic     w_md_result_sel;
    logic     w_timeout_set;

    exe_hazard_ctrl_fwd_sel #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_a (
        .i_rs_addr (bus.rs1_addr_exe),
        .i_rd_mem  (bus.rd_addr_mem),
        .i_we_mem  (bus.reg_write_mem),
        .i_rd_wb   (bus.rd_addr_wb),
        .i_we_wb   (bus.reg_write_wb),
        .o_sel     (w_fwd_a)
    );

    exe_hazard_ctrl_fwd_sel #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_b (
        .i_rs_addr (bus.rs2_addr_exe),
        .i_rd_mem  (bus.rd_addr_mem),
        .i_we_mem  (bus.reg_write_mem),
        .i_rd_wb   (bus.rd_addr_wb),
        .i_we_wb   (bus.reg_write_wb),
        .o_sel     (w_fwd_b)
    );

    assign w_load_use = bus.mem_read_exe && (bus.rd_addr_exe != '0) &&
                        ((bus.rd_addr_exe == bus.rs1_addr_id) ||
                         (bus.rd_addr_exe == bus.rs2_addr_id));

    // Counter holds cycles already spent waiting, so the last allowed
    // busy cycle is the one where it sits one below the limit
    assign w_wd_hit = (r_md_cnt == MD_CNT_WIDTH'(MD_MAX_CYCLES - 1));

    // Next-state and pipeline controls; everything forced low in reset
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_pc      = 1'b0;
        w_stall_id      = 1'b0;
        w_stall_exe     = 1'b0;
        w_bubble_exe    = 1'b0;
        w_bubble_mem    = 1'b0;
        w_md_start      = 1'b0;
        w_md_abort      = 1'b0;
        w_md_result_sel = 1'b0;
        w_timeout_set   = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        w_bubble_exe = 1'b1;
                    end else if (bus.md_op_exe) begin
                        w_md_start   = 1'b1;
                        w_stall_pc   = 1'b1;
                        w_stall_id   = 1'b1;
                        w_stall_exe  = 1'b1;
                        w_bubble_mem = 1'b1;
                        w_state_nxt  = MD_BUSY;
                    end else if (w_load_use) begin
                        w_stall_pc   = 1'b1;
                        w_stall_id   = 1'b1;
                        w_bubble_exe = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (bus.flush) begin
                        w_md_abort   = 1'b1;
                        w_bubble_exe = 1'b1;
                        w_bubble_mem = 1'b1;
                        w_state_nxt  = IDLE;
                    end else if (bus.md_done) begin
                        w_stall_pc   = 1'b1;
                        w_stall_id   = 1'b1;
                        w_stall_exe  = 1'b1;
                        w_bubble_mem = 1'b1;
                        w_state_nxt  = MD_DONE;
                    end else if (w_wd_hit) begin
                        w_md_abort    = 1'b1;
                        w_bubble_mem  = 1'b1;
                        w_timeout_set = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_stall_pc   = 1'b1;
                        w_stall_id   = 1'b1;
                        w_stall_exe  = 1'b1;
                        w_bubble_mem = 1'b1;
                    end
                end
                MD_DONE: begin
                    w_state_nxt = IDLE;
                    if (bus.flush) begin
                        w_bubble_exe = 1'b1;
                        w_bubble_mem = 1'b1;
                    end else begin
                        w_md_result_sel = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, watchdog, sticky timeout and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_md_cnt      <= '0;
            r_md_timeout  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_md_start) begin
                r_md_cnt <= '0;
            end else if (r_state == MD_BUSY) begin
                r_md_cnt <= r_md_cnt + MD_CNT_WIDTH'(1);
            end
            if (w_timeout_set) begin
                r_md_timeout <= 1'b1;
            end
            if (w_stall_pc && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.forward_a_sel = rst_n ? w_fwd_a : FORWARD_SEL_EXE;
    assign bus.forward_b_sel = rst_n ? w_fwd_b : FORWARD_SEL_EXE;
    assign bus.stall_pc      = w_stall_pc;
    assign bus.stall_id      = w_stall_id;
    assign bus.stall_exe     = w_stall_exe;
    assign bus.bubble_exe    = w_bubble_exe;
    assign bus.bubble_mem    = w_bubble_mem;
    assign bus.md_start      = w_md_start;
    assign bus.md_abort      = w_md_abort;
    assign bus.md_result_sel = w_md_result_sel;
    assign bus.md_timeout    = r_md_timeout;
    assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model.
module tb_exe_hazard_ctrl;
    import exe_hazard_ctrl_pkg::*;

    localparam int AW    = 5;
    localparam int CW    = 8;
    localparam int MDMAX = 64;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    exe_hazard_ctrl_if #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    exe_hazard_ctrl #(
        .REG_ADDR_WIDTH (AW),
        .CNT_WIDTH      (CW),
        .MD_MAX_CYCLES  (MDMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: age = cycles since md_start (0 = no op)
    int m_age;
    bit m_fin;
    int m_cnt;
    bit m_to;

    // observed outputs of the last modelled cycle
    int o_fa, o_fb, o_cnt;
    bit o_spc, o_sid, o_sexe, o_bex, o_bmem;
    bit o_st, o_ab, o_rs, o_to;
    int n_start, n_stall;

    task automatic chk(string tag, int unsigned got, int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fexp(int rs);
        if (bus.reg_write_mem && bus.rd_addr_mem != 0 && int'(bus.rd_addr_mem) == rs)
            return 1;
        if (bus.reg_write_wb && bus.rd_addr_wb != 0 && int'(bus.rd_addr_wb) == rs)
            return 2;
        return 0;
    endfunction

    task automatic clr_in();
        bus.rs1_addr_id   = '0;
        bus.rs2_addr_id   = '0;
        bus.rs1_addr_exe  = '0;
        bus.rs2_addr_exe  = '0;
        bus.rd_addr_exe   = '0;
        bus.mem_read_exe  = 1'b0;
        bus.md_op_exe     = 1'b0;
        bus.rd_addr_mem   = '0;
        bus.reg_write_mem = 1'b0;
        bus.rd_addr_wb    = '0;
        bus.reg_write_wb  = 1'b0;
        bus.flush         = 1'b0;
        bus.md_done       = 1'b0;
    endtask

    task automatic m_reset();
        m_age = 0;
        m_fin = 0;
        m_cnt = 0;
        m_to  = 0;
    endtask

    // called at posedge+1 with inputs set; checks mid-cycle, then advances
    task automatic cyc();
        int ea, eb;
        bit lu, spc, sid, sexe, bex, bmem, st, ab, rs, tos;
        #4;
        ea = fexp(int'(bus.rs1_addr_exe));
        eb = fexp(int'(bus.rs2_addr_exe));
        lu = bus.mem_read_exe && bus.rd_addr_exe != 0 &&
             (bus.rd_addr_exe == bus.rs1_addr_id || bus.rd_addr_exe == bus.rs2_addr_id);
        {spc, sid, sexe, bex, bmem, st, ab, rs, tos} = '0;
        if (m_fin) begin
            if (bus.flush) begin bex = 1; bmem = 1; end
            else rs = 1;
        end else if (m_age > 0) begin
            if (bus.flush) begin ab = 1; bex = 1; bmem = 1; end
            else if (bus.md_done) begin spc = 1; sid = 1; sexe = 1; bmem = 1; end
            else if (m_age == MDMAX) begin ab = 1; bmem = 1; tos = 1; end
            else begin spc = 1; sid = 1; sexe = 1; bmem = 1; end
        end else begin
            if (bus.flush) bex = 1;
            else if (bus.md_op_exe) begin st = 1; spc = 1; sid = 1; sexe = 1; bmem = 1; end
            else if (lu) begin spc = 1; sid = 1; bex = 1; end
        end
        o_fa = int'(bus.forward_a_sel);  o_fb  = int'(bus.forward_b_sel);
        o_spc = bus.stall_pc;   o_sid = bus.stall_id;  o_sexe = bus.stall_exe;
        o_bex = bus.bubble_exe; o_bmem = bus.bubble_mem;
        o_st = bus.md_start;    o_ab = bus.md_abort;   o_rs = bus.md_result_sel;
        o_to = bus.md_timeout;  o_cnt = int'(bus.stall_count);
        chk("fwd_a", o_fa, ea);
        chk("fwd_b", o_fb, eb);
        chk("stall_pc", o_spc, spc);
        chk("stall_id", o_sid, sid);
        chk("stall_exe", o_sexe, sexe);
        chk("bubble_exe", o_bex, bex);
        chk("bubble_mem", o_bmem, bmem);
        chk("md_start", o_st, st);
        chk("md_abort", o_ab, ab);
        chk("md_result_sel", o_rs, rs);
        chk("md_timeout", o_to, m_to);
        chk("stall_count", o_cnt, m_cnt);
        n_start += int'(o_st);
        n_stall += int'(o_spc);
        if (spc && m_cnt < CMAX) m_cnt++;
        if (tos) m_to = 1;
        if (m_fin) m_fin = 0;
        else if (m_age > 0) begin
            if (bus.flush || tos) m_age = 0;
            else if (bus.md_done) begin m_age = 0; m_fin = 1; end
            else m_age++;
        end else if (st) m_age = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        n_start = 0;
        n_stall = 0;
    endtask

    initial begin
        clr_in();
        m_reset();
        n_start = 0;
        n_stall = 0;
        rst_n = 1'b0;
        bus.rs1_addr_exe  = 5'd3;
        bus.rd_addr_mem   = 5'd3;
        bus.reg_write_mem = 1'b1;
        bus.md_op_exe     = 1'b1;
        #2;
        chk("rst_fwd_a", int'(bus.forward_a_sel), 0);
        chk("rst_stall_pc", bus.stall_pc, 0);
        chk("rst_md_start", bus.md_start, 0);
        chk("rst_count", int'(bus.stall_count), 0);
        chk("rst_timeout", bus.md_timeout, 0);
        @(posedge clk);
        #1;
        do_reset();

        // forwarding priority and x0 rule
        bus.rd_addr_mem = 5'd5; bus.reg_write_mem = 1'b1;
        bus.rd_addr_wb  = 5'd5; bus.reg_write_wb  = 1'b1;
        bus.rs1_addr_exe = 5'd5; bus.rs2_addr_exe = 5'd5;
        cyc();
        chk("fwd_mem", o_fa, 1);
        bus.rd_addr_mem = 5'd0;
        cyc();
        chk("fwd_wb", o_fa, 2);
        bus.rs1_addr_exe = 5'd0; bus.rd_addr_wb = 5'd0;
        cyc();
        chk("fwd_x0", o_fa, 0);
        bus.rd_addr_wb = 5'd9; bus.rs2_addr_exe = 5'd9;
        cyc();
        chk("fwd_b_wb", o_fb, 2);
        clr_in();

        // load-use: one stall cycle
        do_reset();
        bus.mem_read_exe = 1'b1; bus.rd_addr_exe = 5'd7; bus.rs2_addr_id = 5'd7;
        cyc();
        chk("lu_stall", int'({o_spc, o_sid, o_bex}), 7);
        clr_in();
        cyc();
        chk("lu_release", o_spc, 0);
        chk("lu_count", o_cnt, 1);

        // flush in IDLE masks md_start and load-use
        bus.flush = 1'b1; bus.md_op_exe = 1'b1;
        bus.mem_read_exe = 1'b1; bus.rd_addr_exe = 5'd4; bus.rs1_addr_id = 5'd4;
        cyc();
        chk("idle_flush_start", o_st, 0);
        chk("idle_flush_bex", o_bex, 1);
        clr_in();

        // MUL/DIV with md_done 33 cycles after start
        do_reset();
        bus.md_op_exe = 1'b1;
        cyc();
        for (int i = 1; i <= 33; i++) begin
            bus.md_done = (i == 33);
            cyc();
        end
        bus.md_done = 1'b0; bus.md_op_exe = 1'b0;
        cyc();
        chk("md_result", o_rs, 1);
        chk("md_done_nostall", o_spc, 0);
        cyc();
        chk("md_count", o_cnt, 34);
        chk("md_starts", n_start, 1);
        chk("md_stalls", n_stall, 34);

        // flush with simultaneous md_done in busy cycle 10
        do_reset();
        bus.md_op_exe = 1'b1;
        cyc();
        for (int i = 1; i < 10; i++) cyc();
        bus.flush = 1'b1; bus.md_done = 1'b1;
        cyc();
        chk("fl_abort", o_ab, 1);
        chk("fl_result", o_rs, 0);
        chk("fl_bubbles", int'({o_bex, o_bmem}), 3);
        clr_in();
        cyc();
        chk("fl_idle", int'({o_spc, o_rs}), 0);

        // watchdog: md_done never arrives
        do_reset();
        bus.md_op_exe = 1'b1;
        cyc();
        begin
            int k;
            k = 1;
            while (k <= 80) begin
                cyc();
                if (o_ab) break;
                k++;
            end
            chk("wd_cycle", k, 64);
        end
        bus.md_op_exe = 1'b0;
        cyc();
        chk("wd_timeout", o_to, 1);
        bus.md_op_exe = 1'b1;
        cyc();
        bus.md_done = 1'b1;
        cyc();
        bus.md_done = 1'b0; bus.md_op_exe = 1'b0;
        cyc();
        cyc();
        chk("wd_sticky", o_to, 1);
        do_reset();
        cyc();
        chk("wd_cleared", o_to, 0);

        // async reset mid-operation
        bus.md_op_exe = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.rs1_addr_exe = 5'd6; bus.rd_addr_mem = 5'd6; bus.reg_write_mem = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fwd", int'(bus.forward_a_sel), 0);
        chk("arst_stall", int'({bus.stall_pc, bus.stall_id, bus.stall_exe}), 0);
        chk("arst_bubble", int'({bus.bubble_exe, bus.bubble_mem}), 0);
        chk("arst_abort", bus.md_abort, 0);
        chk("arst_count", int'(bus.stall_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        clr_in();
        cyc();
        chk("arst_idle", o_spc, 0);

        // saturation of the stall counter
        do_reset();
        for (int op = 0; op < 5; op++) begin
            bus.md_op_exe = 1'b1;
            cyc();
            for (int j = 1; j <= 59; j++) begin
                bus.md_done = (j == 59);
                cyc();
            end
            bus.md_done = 1'b0; bus.md_op_exe = 1'b0;
            cyc();
        end
        cyc();
        chk("sat_count", o_cnt, CMAX);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.rs1_addr_id   = AW'($urandom_range(0, 3));
            bus.rs2_addr_id   = AW'($urandom_range(0, 3));
            bus.rs1_addr_exe  = AW'($urandom_range(0, 3));
            bus.rs2_addr_exe  = AW'($urandom_range(0, 3));
            bus.rd_addr_exe   = AW'($urandom_range(0, 3));
            bus.rd_addr_mem   = AW'($urandom_range(0, 3));
            bus.rd_addr_wb    = AW'($urandom_range(0, 3));
            bus.mem_read_exe  = ($urandom_range(0, 2) == 0);
            bus.reg_write_mem = $urandom_range(0, 1) != 0;
            bus.reg_write_wb  = $urandom_range(0, 1) != 0;
            bus.md_op_exe     = ($urandom_range(0, 5) == 0);
            bus.md_done       = ($urandom_range(0, 19) == 0);
            bus.flush         = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
